// File: rtl/stack_cmd_arbiter.sv
// stack_cmd_arbiter: two-requester round-robin arbiter that issues one opcode
// at a time to a stack and returns the stack's head and empty flag to the winner.
//
// Optional build macro STACK_ARB_TIMEOUT_EN adds a WAIT timeout of TO_CYC cycles.
// When the macro is enabled, a timed-out command completes with rN_err high.
// Without the macro, WAIT is left only on stk_valid and rN_err is tied low.
//
// Handshakes:
// - rN_req is raised and held with a stable rN_op/rN_in until the rN_ack pulse.
// - stk_apply is a single-cycle strobe with stk_op/stk_in.
// - The stack answers with stk_valid. It is sampled only while waiting, and can
//   already be high in the first waiting cycle.
module stack_cmd_arbiter #(
    parameter int W      = 16,
    parameter int TO_CYC = 15
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_r0_req,
    input  logic [3:0]   i_r0_op,
    input  logic [W-1:0] i_r0_in,
    output logic         o_r0_ack,
    output logic         o_r0_err,
    input  logic         i_r1_req,
    input  logic [3:0]   i_r1_op,
    input  logic [W-1:0] i_r1_in,
    output logic         o_r1_ack,
    output logic         o_r1_err,
    output logic [W-1:0] o_rsp_head,
    output logic         o_rsp_empty,
    output logic         o_busy,
    output logic [3:0]   o_stk_op,
    output logic [W-1:0] o_stk_in,
    output logic         o_stk_apply,
    input  logic [W-1:0] i_stk_head,
    input  logic         i_stk_empty,
    input  logic         i_stk_valid,
    output logic [1:0]   o_dbg_state
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    // An out-of-range timeout setting is rejected at elaboration.
    if (TO_CYC < 1 || TO_CYC > 255) begin : g_to_cyc_range
        $error("stack_cmd_arbiter: TO_CYC must be within 1..255");
    end

    state_t       r_state;
    logic         r_ptr;     // requester that wins the next tie
    logic         r_gnt;     // requester owning the command in flight
    logic [3:0]   r_op;
    logic [W-1:0] r_in;
    logic         r_apply;
    logic         r_ack0;
    logic         r_ack1;
    logic [W-1:0] r_head;
    logic         r_empty;
    logic         r_busy;

    logic         w_any;
    logic         w_gnt;

    assign w_any = i_r0_req | i_r1_req;
    // A lone requester wins outright; a tie goes to the pointer.
    assign w_gnt = (i_r0_req && i_r1_req) ? r_ptr : ~i_r0_req;

`ifdef STACK_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TO_CYC - 1);
    logic [7:0] r_cnt;
    logic       r_err0;
    logic       r_err1;
    assign o_r0_err = r_err0;
    assign o_r1_err = r_err1;
`else
    assign o_r0_err = 1'b0;
    assign o_r1_err = 1'b0;
`endif

    // Command FSM: grant, issue strobe, wait for the stack, report completion.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_ptr   <= 1'b0;
            r_gnt   <= 1'b0;
            r_op    <= '0;
            r_in    <= '0;
            r_apply <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_head  <= '0;
            r_empty <= 1'b1;
            r_busy  <= 1'b0;
`ifdef STACK_ARB_TIMEOUT_EN
            r_cnt   <= '0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state <= S_ISSUE;
                        r_gnt   <= w_gnt;
                        r_ptr   <= ~w_gnt;
                        r_op    <= w_gnt ? i_r1_op : i_r0_op;
                        r_in    <= w_gnt ? i_r1_in : i_r0_in;
                        r_apply <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                    r_apply <= 1'b0;
`ifdef STACK_ARB_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                end
                S_WAIT: begin
                    if (i_stk_valid) begin
                        r_state <= S_DONE;
                        r_head  <= i_stk_head;
                        r_empty <= i_stk_empty;
                        r_ack0  <= ~r_gnt;
                        r_ack1  <= r_gnt;
                    end
`ifdef STACK_ARB_TIMEOUT_EN
                    else if (r_cnt == TO_LAST) begin
                        // Give up: report an error and keep the previous response.
                        r_state <= S_DONE;
                        r_ack0  <= ~r_gnt;
                        r_ack1  <= r_gnt;
                        r_err0  <= ~r_gnt;
                        r_err1  <= r_gnt;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
`endif
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_busy  <= 1'b0;
`ifdef STACK_ARB_TIMEOUT_EN
                    r_err0  <= 1'b0;
                    r_err1  <= 1'b0;
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_r0_ack    = r_ack0;
    assign o_r1_ack    = r_ack1;
    assign o_rsp_head  = r_head;
    assign o_rsp_empty = r_empty;
    assign o_busy      = r_busy;
    assign o_stk_op    = r_op;
    assign o_stk_in    = r_in;
    assign o_stk_apply = r_apply;
    assign o_dbg_state = r_state;

endmodule

// File: doc/stack_cmd_arbiter.md
STACK_CMD_ARBITER -- requirements
Module: stack_cmd_arbiter

Interface
REQ-001 Parameter W, default 16: data width of operands and stack head.
REQ-002 Parameter TO_CYC, default 15: maximum cycles to wait for stk_valid, range 1..255.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 rN_req  input  1  requester N (N=0,1) command request, held high until rN_ack.
REQ-006 rN_op  input  4  requester N stack opcode, opaque to this block, stable while rN_req is high.
REQ-007 rN_in  input  W  requester N operand, stable while rN_req is high.
REQ-008 rN_ack  output  1  one-cycle pulse: requester N command completed.
REQ-009 rN_err  output  1  valid with rN_ack: command timed out.
REQ-010 rsp_head  output  W  stack head captured at completion.
REQ-011 rsp_empty  output  1  stack empty flag captured at completion.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 stk_op  output  4  opcode to stack; stk_in  output  W  operand to stack; stk_apply  output  1  command strobe to stack.
REQ-014 stk_head  input  W, stk_empty  input  1, stk_valid  input  1: stack results.

Function
REQ-015 FSM states IDLE, ISSUE, WAIT, DONE; IDLE->ISSUE when any rN_req is high; ISSUE->WAIT unconditionally; WAIT->DONE on stk_valid or timeout; DONE->IDLE unconditionally.
REQ-016 Grant decided on the IDLE->ISSUE edge: single requester wins outright; both requesting -> requester named by the round-robin pointer wins.
REQ-017 Round-robin pointer resets to 0 and moves to the non-granted requester on every IDLE->ISSUE edge.
REQ-018 Granted rN_op/rN_in registered on the grant edge; stk_op/stk_in are driven from these registers and remain constant from ISSUE through DONE.
REQ-019 stk_apply high for exactly the ISSUE cycle, otherwise low.
REQ-020 stk_valid ignored outside WAIT; stk_valid already high during the first WAIT cycle completes the command.
REQ-021 On WAIT->DONE, stk_head/stk_empty captured into rsp_head/rsp_empty; these hold until the next completion.
REQ-022 In DONE, granted rN_ack high for one cycle; the other ack stays low.
REQ-023 Minimum latency: req sampled at edge k, stk_apply during cycle k..k+1, ack high the cycle after the stk_valid edge (k+3 best case).
REQ-024 A requester whose req stays high after its ack may be regranted from the following IDLE cycle, subject to round-robin.
REQ-025 Dropping rN_req before ack is a protocol violation; the command completes regardless.

Reset
REQ-026 rst low asynchronously forces IDLE, pointer 0, stk_apply 0, stk_op 0, stk_in 0, rN_ack 0, rN_err 0, rsp_head 0, rsp_empty 1, busy 0, timeout counter 0.
REQ-027 Reset mid-command abandons it with no ack; the first grant after release follows REQ-016 with pointer 0.

Configuration
REQ-028 Macro STACK_ARB_TIMEOUT_EN defined: 8-bit counter cleared on entering WAIT, incremented per WAIT cycle; counter reaching TO_CYC without stk_valid -> DONE with rN_err 1, rsp_head/rsp_empty unchanged.
REQ-029 Macro undefined: no counter, WAIT left only on stk_valid, rN_err tied to 0.

Verification
REQ-030 Reset: rst low mid-WAIT -> all outputs at REQ-026 values immediately, busy 0, no ack pulse.
REQ-031 Single push: r0_req, r0_op=7, r0_in=150; stack stk_valid 1 cycle after apply with stk_head=150 -> stk_apply one cycle with stk_op=7, stk_in=150; r0_ack pulse, rsp_head=150, rsp_empty=0, r0_err=0.
REQ-032 Contention: r0 and r1 request on the same edge, held -> grant order r0, r1, r0, r1; acks alternate, never both high.
REQ-033 Late valid: stk_valid 6 cycles after apply, op=5 -> stk_op=5 held through WAIT, one apply pulse only, ack the cycle after valid.
REQ-034 Timeout (macro defined, TO_CYC=15): stk_valid never asserted -> r1_ack and r1_err high together 15 WAIT cycles later, rsp_head unchanged.
REQ-035 Macro undefined, same stimulus -> busy stays 1, no ack, until stk_valid is driven.
